wifi_tx_interleaver_param: RTL and testbench

WIFI_TX_INTERLEAVER_PARAM -- requirements
Module: WIFI_TX_interleaver_param

---
 rtl/wifi_tx_interleaver_param_if.sv | 21 ++
 rtl/wifi_tx_interleaver_param.sv | 171 +++++++++++++++++
 tb/tb_wifi_tx_interleaver_param.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wifi_tx_interleaver_param_if.sv
// Serial bit-stream bundle between the coded-bit source and the 802.11a TX interleaver.
// The master side drives coded bits and the mode select; the slave side returns interleaved bits.
interface wifi_tx_interleaver_param_if;
    logic       enable;
    logic       valid_in;
    logic       data_in;
    logic [1:0] mod_sel;
    logic       valid_out;
    logic       data_out;
    logic       finished;

    modport master (
        output enable, valid_in, data_in, mod_sel,
        input  valid_out, data_out, finished
    );

    modport slave (
        input  enable, valid_in, data_in, mod_sel,
        output valid_out, data_out, finished
    );
endinterface

// File: rtl/wifi_tx_interleaver_param.sv
// 802.11a/g block interleaver: ping-pong bit banks written at permuted addresses j(k)
// and read back sequentially, one bit per enabled cycle, with per-symbol NBPSC.
module wifi_tx_interleaver_param #(
    parameter int MAX_NBPSC = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    wifi_tx_interleaver_param_if.slave   bus
);
    localparam int DEPTH = 48 * MAX_NBPSC;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, LAST} rd_state_t;

    function automatic logic [2:0] sel_nbpsc(input logic [1:0] m);
        logic [2:0] nb;
        case (m)
            2'd0:    nb = 3'd1;
            2'd1:    nb = 3'd2;
            2'd2:    nb = 3'd4;
            default: nb = 3'd6;
        endcase
        if (int'(nb) > MAX_NBPSC) nb = 3'(MAX_NBPSC);
        return nb;
    endfunction

    function automatic logic [1:0] s_of(input logic [2:0] nb);
        case (nb)
            3'd4:    return 2'd2;
            3'd6:    return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    logic            mem_q [2][DEPTH];
    logic [3:0]      col_q;
    logic [4:0]      row_q;
    logic [1:0]      col_m3_q, row_m3_q;
    logic [AW-1:0]   base_q;
    logic [2:0]      wr_nbpsc_q;
    logic            wr_bank_q;
    logic [2:0]      bank_nb_q [2];
    logic [1:0]      bank_full_q, bank_full_d;
    rd_state_t       state_q;
    logic            rd_bank_q;
    logic [AW-1:0]   rd_addr_q;
    logic            valid_out_q, data_out_q, finished_q;

    logic            accept, first, last_bit;
    logic [2:0]      nb_cur;
    logic [4:0]      rpc;
    logic [1:0]      s, rm, cm, off;
    logic [AW-1:0]   wr_addr;
    logic [2:0]      rd_nb;
    logic [9:0]      rd_ncbps;

    assign accept   = bus.enable & bus.valid_in;
    assign first    = (col_q == 4'd0) && (row_q == 5'd0);
    assign nb_cur   = first ? sel_nbpsc(bus.mod_sel) : wr_nbpsc_q;
    assign rpc      = 5'({nb_cur, 1'b0}) + 5'(nb_cur);
    assign last_bit = (col_q == 4'd15) && (row_q == rpc - 5'd1);
    assign s        = s_of(nb_cur);

    // base_q is a multiple of s, so i mod s == row mod s and (i - col) mod s == (row - col) mod s.
    assign rm      = (s == 2'd3) ? row_m3_q : (s == 2'd2) ? {1'b0, row_q[0]} : 2'd0;
    assign cm      = (s == 2'd3) ? col_m3_q : (s == 2'd2) ? {1'b0, col_q[0]} : 2'd0;
    assign off     = (rm >= cm) ? (rm - cm) : (rm + s - cm);
    assign wr_addr = base_q + AW'(row_q) - AW'(rm) + AW'(off);

    assign rd_nb    = bank_nb_q[rd_bank_q];
    assign rd_ncbps = 10'({rd_nb, 5'b0}) + 10'({rd_nb, 4'b0});

    always_comb begin
        bank_full_d = bank_full_q;
        if (bus.enable && state_q == LAST) bank_full_d[rd_bank_q] = 1'b0;
        if (accept && last_bit)            bank_full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_bank_q][wr_addr] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            col_m3_q     <= '0;
            row_m3_q     <= '0;
            base_q       <= '0;
            wr_nbpsc_q   <= '0;
            wr_bank_q    <= 1'b0;
            bank_nb_q[0] <= '0;
            bank_nb_q[1] <= '0;
            bank_full_q  <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            if (accept) begin
                if (first) wr_nbpsc_q <= nb_cur;
                if (last_bit) begin
                    col_q                <= '0;
                    row_q                <= '0;
                    col_m3_q             <= '0;
                    row_m3_q             <= '0;
                    base_q               <= '0;
                    wr_bank_q            <= ~wr_bank_q;
                    bank_nb_q[wr_bank_q] <= nb_cur;
                end else if (col_q == 4'd15) begin
                    col_q    <= '0;
                    col_m3_q <= '0;
                    base_q   <= '0;
                    row_q    <= row_q + 5'd1;
                    row_m3_q <= (row_m3_q == 2'd2) ? 2'd0 : row_m3_q + 2'd1;
                end else begin
                    col_q    <= col_q + 4'd1;
                    col_m3_q <= (col_m3_q == 2'd2) ? 2'd0 : col_m3_q + 2'd1;
                    base_q   <= base_q + AW'(rpc);
                end
            end
        end
    end

    // Reader: LAST emits the final bit and hands straight over to the other bank when it is full.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= 1'b0;
            finished_q  <= 1'b0;
        end else if (!bus.enable) begin
            valid_out_q <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_out_q <= 1'b0;
                    finished_q  <= 1'b0;
                    if (bank_full_q[rd_bank_q]) begin
                        state_q   <= READ;
                        rd_addr_q <= '0;
                    end
                end
                READ: begin
                    valid_out_q <= 1'b1;
                    finished_q  <= 1'b0;
                    data_out_q  <= mem_q[rd_bank_q][rd_addr_q];
                    rd_addr_q   <= rd_addr_q + AW'(1);
                    if (10'(rd_addr_q) == rd_ncbps - 10'd2) state_q <= LAST;
                end
                LAST: begin
                    valid_out_q <= 1'b1;
                    finished_q  <= 1'b1;
                    data_out_q  <= mem_q[rd_bank_q][rd_addr_q];
                    rd_addr_q   <= '0;
                    rd_bank_q   <= ~rd_bank_q;
                    state_q     <= bank_full_q[~rd_bank_q] ? READ : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.finished  = finished_q;

    // Writing into a bank the reader has not yet released would corrupt an unread symbol.
    assert property (@(posedge clk) disable iff (reset) !(accept && bank_full_q[wr_bank_q]));

endmodule

// File: tb/tb_wifi_tx_interleaver_param.sv
// Scoreboard bench for wifi_tx_interleaver_param: directed single-one symbols with hand-computed
// output positions, back-to-back mixed modes, input gaps, enable freeze and mid-symbol reset.
module tb_wifi_tx_interleaver_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wifi_tx_interleaver_param_if bus();

    wifi_tx_interleaver_param #(.MAX_NBPSC(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic d;
        logic f;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   run_len  = 0;
    int   last_run = 0;
    int   fin_cnt  = 0;
    int   vld_cnt  = 0;
    logic prev_v   = 1'b0;

    // Monitor: every presented output bit is popped and compared against the expected stream.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            run_len = 0;
            prev_v  = 1'b0;
        end else begin
            if (bus.valid_out) begin
                run_len++;
                vld_cnt++;
                if (bus.finished) fin_cnt++;
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output data_out=%0b finished=%0b required=no_output",
                             bus.data_out, bus.finished);
                end else begin
                    e = expq.pop_front();
                    if ({bus.data_out, bus.finished} !== {e.d, e.f}) begin
                        failures++;
                        $display("FAIL out_bit data_out=%0b finished=%0b required data_out=%0b finished=%0b",
                                 bus.data_out, bus.finished, e.d, e.f);
                    end
                end
            end else begin
                if (prev_v) last_run = run_len;
                run_len = 0;
                checks++;
                if (bus.finished !== 1'b0) begin
                    failures++;
                    $display("FAIL finished_without_valid finished=%0b required=0", bus.finished);
                end
            end
            prev_v = bus.valid_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Sends nsend bits of an n-bit symbol with a single 1 at k=onek; expected stream pushed only for full symbols.
    task automatic send_sym(input logic [1:0] ms, input int n, input int onek, input int exppos,
                            input int nsend, input bit toggle, input int gapk);
        exp_t e;
        if (nsend == n) begin
            for (int p = 0; p < n; p++) begin
                e.d = (p == exppos);
                e.f = (p == n - 1);
                expq.push_back(e);
            end
        end
        for (int k = 0; k < nsend; k++) begin
            if (k == gapk) begin
                bus.valid_in = 1'b0;
                bus.data_in  = 1'b1;
                repeat (3) tick();
            end
            bus.valid_in = 1'b1;
            bus.data_in  = (k == onek);
            bus.mod_sel  = (k == 0 || !toggle) ? ms : (ms ^ 2'b11);
            tick();
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((expq.size() != 0 || bus.valid_out) && t < 3000) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 3000) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", expq.size());
        end
        repeat (3) tick();
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!bus.valid_out && t < 400) begin
            tick();
            t++;
        end
        chk("wait_valid_timeout", int'(t >= 400), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   f0;
        int   v0;
        logic held;

        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = 1'b0;
        bus.mod_sel  = 2'd0;
        repeat (3) tick();
        chk("rst_valid_out", int'(bus.valid_out), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_finished", int'(bus.finished), 0);
        reset = 1'b0;
        tick();

        // BPSK, 1 at k=1 -> position 3; valid_out rises two edges after the last input bit.
        send_sym(2'd0, 48, 1, 3, 48, 1'b0, -1);
        bus.valid_in = 1'b0;
        chk("lat_e1_valid", int'(bus.valid_out), 0);
        tick();
        chk("lat_e1_valid_b", int'(bus.valid_out), 0);
        tick();
        chk("lat_e2_valid", int'(bus.valid_out), 1);
        drain();
        chk("run_bpsk", last_run, 48);

        send_sym(2'd1, 96, 17, 7, 96, 1'b0, -1);
        bus.valid_in = 1'b0;
        drain();
        chk("run_qpsk", last_run, 96);

        send_sym(2'd2, 192, 1, 13, 192, 1'b0, -1);
        bus.valid_in = 1'b0;
        drain();
        chk("run_16qam", last_run, 192);

        send_sym(2'd3, 288, 1, 20, 288, 1'b0, -1);
        bus.valid_in = 1'b0;
        drain();
        chk("run_64qam", last_run, 288);

        send_sym(2'd2, 192, 16, 1, 192, 1'b1, 100);
        bus.valid_in = 1'b0;
        drain();
        chk("run_16qam_gap", last_run, 192);

        send_sym(2'd3, 288, 2, 37, 288, 1'b1, -1);
        bus.valid_in = 1'b0;
        drain();
        chk("run_64qam_k2", last_run, 288);

        // Back-to-back 0,3,1 with mod_sel toggled mid-symbol; the 288->96 handover is seamless.
        f0 = fin_cnt;
        v0 = vld_cnt;
        send_sym(2'd0, 48, 1, 3, 48, 1'b1, -1);
        send_sym(2'd3, 288, 1, 20, 288, 1'b1, -1);
        send_sym(2'd1, 96, 17, 7, 96, 1'b1, -1);
        bus.valid_in = 1'b0;
        drain();
        chk("btb_finished_pulses", fin_cnt - f0, 3);
        chk("btb_valid_total", vld_cnt - v0, 432);
        chk("btb_run_288_96", last_run, 384);

        // Freeze on the output bit carrying the 1, then resume.
        send_sym(2'd1, 96, 17, 7, 96, 1'b0, -1);
        bus.valid_in = 1'b0;
        wait_valid();
        repeat (7) tick();
        chk("pre_freeze_bit", int'(bus.data_out), 1);
        held = bus.data_out;
        bus.enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("freeze_valid", int'(bus.valid_out), 0);
            chk("freeze_finished", int'(bus.finished), 0);
            chk("freeze_data_hold", int'(bus.data_out), int'(held));
        end
        bus.enable = 1'b1;
        drain();

        // Reset with one symbol half read and the next half written.
        send_sym(2'd0, 48, 1, 3, 48, 1'b0, -1);
        send_sym(2'd3, 288, -1, -1, 20, 1'b0, -1);
        chk("pre_reset_valid", int'(bus.valid_out), 1);
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        expq.delete();
        tick();
        chk("rst2_valid_out", int'(bus.valid_out), 0);
        chk("rst2_data_out", int'(bus.data_out), 0);
        chk("rst2_finished", int'(bus.finished), 0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_reset_idle", int'(bus.valid_out), 0);
        end

        send_sym(2'd3, 288, 2, 37, 288, 1'b0, -1);
        bus.valid_in = 1'b0;
        drain();
        chk("run_after_reset", last_run, 288);
        chk("queue_empty_end", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
